// File: rtl/shared_reg_arbiter_if.sv
// Bus bundle for the shared register arbiter: requester-side inputs and
// the registered grant/status/data outputs.
interface shared_reg_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0]       wr_en;
  logic [N_REQ*WIDTH-1:0] d_in;
  logic [N_REQ-1:0]       gnt;
  logic [1:0]             owner;
  logic                   busy;
  logic [WIDTH-1:0]       Q;
  logic                   timeout;

  // Requesters drive the request side and observe the status side.
  modport master (
    output req, wr_en, d_in,
    input  gnt, owner, busy, Q, timeout
  );

  // The arbiter consumes requests and drives the status side.
  modport slave (
    input  req, wr_en, d_in,
    output gnt, owner, busy, Q, timeout
  );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter granting tenure of a single shared register to one of
// N_REQ requesters. A tenure ends when the owner drops its request or after
// MAX_HOLD grant cycles; every release is followed by exactly one idle cycle.
module shared_reg_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               reset,
  shared_reg_arbiter_if.slave bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  // Counter value reached on the last allowed grant cycle.
  localparam logic [3:0] LAST_CNT = 4'(MAX_HOLD - 1);

  logic [0:0]       state_q,   state_d;
  logic [N_REQ-1:0] gnt_q,     gnt_d;
  logic [1:0]       owner_q,   owner_d;
  logic             busy_q,    busy_d;
  logic [WIDTH-1:0] q_q,       q_d;
  logic             timeout_q, timeout_d;
  logic [3:0]       cnt_q,     cnt_d;
  logic [1:0]       last_q,    last_d;

  logic [1:0]       winner;
  logic             found;
  logic [1:0]       cand;
  logic             owner_req;
  logic             owner_wr;
  logic [WIDTH-1:0] owner_data;

  // Round-robin search starting just after the previous owner; the
  // previous owner itself is examined last, giving it lowest priority.
  always_comb begin
    winner = last_q;
    found  = 1'b0;
    cand   = last_q;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = last_q + 2'(k);
      if (!found && bus.req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Current owner's request, strobe and data slice.
  always_comb begin
    owner_req  = bus.req[owner_q];
    owner_wr   = bus.wr_en[owner_q];
    owner_data = bus.d_in[owner_q*WIDTH +: WIDTH];
  end

  // Next-state logic: grant from IDLE, write/count/release in GRANT.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    busy_d    = busy_q;
    q_d       = q_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    last_d    = last_q;
    case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (found) begin
          state_d        = GRANT;
          gnt_d          = '0;
          gnt_d[winner]  = 1'b1;
          owner_d        = winner;
          busy_d         = 1'b1;
        end
      end
      GRANT: begin
        // The owner's write lands even on the releasing edge.
        if (owner_wr) begin
          q_d = owner_data;
        end
        if (!owner_req || (cnt_q == LAST_CNT)) begin
          state_d   = IDLE;
          gnt_d     = '0;
          busy_d    = 1'b0;
          last_d    = owner_q;
          cnt_d     = 4'd0;
          // Only an expiry with the request still held counts as timeout.
          timeout_d = owner_req;
        end else if (cnt_q != 4'hF) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      owner_q   <= 2'd0;
      busy_q    <= 1'b0;
      q_q       <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= 4'd0;
      last_q    <= 2'(N_REQ - 1);
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      q_q       <= q_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.owner   = owner_q;
  assign bus.busy    = busy_q;
  assign bus.Q       = q_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed testbench for shared_reg_arbiter.
module tb_shared_reg_arbiter;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  shared_reg_arbiter_if #(.N_REQ(4), .WIDTH(8)) bus ();

  shared_reg_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // status = {gnt, owner, busy, timeout}
  function automatic logic [7:0] status();
    return {bus.gnt, bus.owner, bus.busy, bus.timeout};
  endfunction

  function automatic logic [7:0] st(input logic [3:0] g, input logic [1:0] o,
                                    input logic b, input logic t);
    return {g, o, b, t};
  endfunction

  task automatic do_reset();
    #2;
    reset = 1'b0;
    #3;
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    bus.req = 4'b0000; bus.wr_en = 4'b0000; bus.d_in = 32'h0;
    reset = 1'b0;
    tick();
    total++;
    if (status() !== st(4'b0000, 2'd0, 1'b0, 1'b0)) begin
      bad++; $display("FAIL reset_status got=%h exp=%h", status(), st(4'b0000, 2'd0, 1'b0, 1'b0));
    end
    total++;
    if (bus.Q !== 8'h00) begin bad++; $display("FAIL reset_q got=%h exp=00", bus.Q); end
    #2; reset = 1'b1; #1;
    $display("test_reset: status=%h Q=%h", status(), bus.Q);
  endtask

  task automatic test_single_write();
    bus.req = 4'b0001; bus.wr_en = 4'b0001; bus.d_in = 32'h0000_00A5;
    tick();
    total++;
    if (status() !== st(4'b0001, 2'd0, 1'b1, 1'b0)) begin
      bad++; $display("FAIL single_grant got=%h exp=%h", status(), st(4'b0001, 2'd0, 1'b1, 1'b0));
    end
    total++;
    if (bus.Q !== 8'h00) begin bad++; $display("FAIL single_no_idle_write got=%h exp=00", bus.Q); end
    tick();
    total++;
    if (bus.Q !== 8'hA5) begin bad++; $display("FAIL single_write got=%h exp=a5", bus.Q); end
    bus.req = 4'b0000; bus.wr_en = 4'b0000;
    tick();
    total++;
    if (status() !== st(4'b0000, 2'd0, 1'b0, 1'b0)) begin
      bad++; $display("FAIL single_release got=%h exp=%h", status(), st(4'b0000, 2'd0, 1'b0, 1'b0));
    end
    tick();
    $display("test_single_write: Q=%h status=%h", bus.Q, status());
  endtask

  task automatic test_round_robin();
    logic [3:0] g;
    do_reset();
    bus.req = 4'b1111; bus.wr_en = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      logic [1:0] o;
      o = 2'(k % 4);
      g = 4'b0001 << o;
      tick();
      total++;
      if (status() !== st(g, o, 1'b1, 1'b0)) begin
        bad++; $display("FAIL rr_grant%0d got=%h exp=%h", k, status(), st(g, o, 1'b1, 1'b0));
      end
      for (int c = 1; c < 4; c++) begin
        tick();
        total++;
        if (status() !== st(g, o, 1'b1, 1'b0)) begin
          bad++; $display("FAIL rr_hold%0d_%0d got=%h exp=%h", k, c, status(), st(g, o, 1'b1, 1'b0));
        end
      end
      tick();
      if (k == 4) bus.req = 4'b0000;
      total++;
      if (status() !== st(4'b0000, o, 1'b0, 1'b1)) begin
        bad++; $display("FAIL rr_expire%0d got=%h exp=%h", k, status(), st(4'b0000, o, 1'b0, 1'b1));
      end
      $display("test_round_robin: tenure %0d owner=%0d status=%h", k, o, status());
    end
    tick();
    total++;
    if (status() !== st(4'b0000, 2'd0, 1'b0, 1'b0)) begin
      bad++; $display("FAIL rr_idle got=%h exp=%h", status(), st(4'b0000, 2'd0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_owner_write();
    bus.req = 4'b0100; bus.wr_en = 4'b0000;
    tick();
    total++;
    if (status() !== st(4'b0100, 2'd2, 1'b1, 1'b0)) begin
      bad++; $display("FAIL ow_grant got=%h exp=%h", status(), st(4'b0100, 2'd2, 1'b1, 1'b0));
    end
    bus.d_in = 32'h4433_2211; bus.wr_en = 4'b1011;
    tick();
    total++;
    if (bus.Q !== 8'h00) begin bad++; $display("FAIL ow_nonowner got=%h exp=00", bus.Q); end
    bus.wr_en = 4'b1111;
    tick();
    total++;
    if (bus.Q !== 8'h33) begin bad++; $display("FAIL ow_all got=%h exp=33", bus.Q); end
    bus.d_in = 32'h88_77_66_55; bus.wr_en = 4'b1101; bus.req = 4'b0000;
    tick();
    total++;
    if (bus.Q !== 8'h77) begin bad++; $display("FAIL ow_release_write got=%h exp=77", bus.Q); end
    total++;
    if (status() !== st(4'b0000, 2'd2, 1'b0, 1'b0)) begin
      bad++; $display("FAIL ow_release got=%h exp=%h", status(), st(4'b0000, 2'd2, 1'b0, 1'b0));
    end
    bus.wr_en = 4'b0000;
    tick();
    $display("test_owner_write: Q=%h status=%h", bus.Q, status());
  endtask

  task automatic test_voluntary_at_expiry();
    bus.req = 4'b0010;
    tick();
    total++;
    if (status() !== st(4'b0010, 2'd1, 1'b1, 1'b0)) begin
      bad++; $display("FAIL vol_grant got=%h exp=%h", status(), st(4'b0010, 2'd1, 1'b1, 1'b0));
    end
    tick(); tick(); tick();
    total++;
    if (status() !== st(4'b0010, 2'd1, 1'b1, 1'b0)) begin
      bad++; $display("FAIL vol_hold got=%h exp=%h", status(), st(4'b0010, 2'd1, 1'b1, 1'b0));
    end
    bus.req = 4'b0000;
    tick();
    total++;
    if (status() !== st(4'b0000, 2'd1, 1'b0, 1'b0)) begin
      bad++; $display("FAIL vol_release got=%h exp=%h", status(), st(4'b0000, 2'd1, 1'b0, 1'b0));
    end
    tick();
    $display("test_voluntary_at_expiry: status=%h", status());
  endtask

  task automatic test_async_reset();
    bus.req = 4'b0100; bus.wr_en = 4'b0100; bus.d_in = 32'h003C_0000;
    tick();
    total++;
    if (status() !== st(4'b0100, 2'd2, 1'b1, 1'b0)) begin
      bad++; $display("FAIL ar_grant got=%h exp=%h", status(), st(4'b0100, 2'd2, 1'b1, 1'b0));
    end
    tick();
    total++;
    if (bus.Q !== 8'h3C) begin bad++; $display("FAIL ar_write got=%h exp=3c", bus.Q); end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (bus.Q !== 8'h00) begin bad++; $display("FAIL ar_async_q got=%h exp=00", bus.Q); end
    total++;
    if (status() !== st(4'b0000, 2'd0, 1'b0, 1'b0)) begin
      bad++; $display("FAIL ar_async_status got=%h exp=%h", status(), st(4'b0000, 2'd0, 1'b0, 1'b0));
    end
    tick();
    total++;
    if ({bus.Q, status()} !== {8'h00, st(4'b0000, 2'd0, 1'b0, 1'b0)}) begin
      bad++; $display("FAIL ar_held got=%h exp=%h", {bus.Q, status()}, {8'h00, st(4'b0000, 2'd0, 1'b0, 1'b0)});
    end
    #2;
    reset = 1'b1;
    bus.req = 4'b1000; bus.wr_en = 4'b0000;
    tick();
    total++;
    if (status() !== st(4'b1000, 2'd3, 1'b1, 1'b0)) begin
      bad++; $display("FAIL ar_regrant got=%h exp=%h", status(), st(4'b1000, 2'd3, 1'b1, 1'b0));
    end
    bus.req = 4'b0000;
    tick();
    tick();
    $display("test_async_reset: status=%h Q=%h", status(), bus.Q);
  endtask

  task automatic test_idle_bus();
    bus.req = 4'b0001; bus.wr_en = 4'b0001; bus.d_in = 32'h0000_005A;
    tick();
    total++;
    if (status() !== st(4'b0001, 2'd0, 1'b1, 1'b0)) begin
      bad++; $display("FAIL idle_grant got=%h exp=%h", status(), st(4'b0001, 2'd0, 1'b1, 1'b0));
    end
    tick();
    bus.req = 4'b0000; bus.wr_en = 4'b0000;
    tick();
    tick();
    bus.wr_en = 4'b1111; bus.d_in = 32'hFFFF_FFFF;
    for (int c = 0; c < 10; c++) begin
      tick();
      total++;
      if ({bus.Q, status()} !== {8'h5A, st(4'b0000, 2'd0, 1'b0, 1'b0)}) begin
        bad++; $display("FAIL idle_cycle%0d got=%h exp=%h", c, {bus.Q, status()}, {8'h5A, st(4'b0000, 2'd0, 1'b0, 1'b0)});
      end
    end
    bus.wr_en = 4'b0000;
    $display("test_idle_bus: Q=%h status=%h", bus.Q, status());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.req = 4'b0000; bus.wr_en = 4'b0000; bus.d_in = 32'h0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_owner_write();
    test_voluntary_at_expiry();
    test_async_reset();
    test_idle_bus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
